id_ex_operand_stage: RTL and testbench
======================================

Name: id_ex_operand_stage

Overview:
ID/EX pipeline register plus operand forwarding and load-use hazard detection for the 5-stage MIPS pipeline. Captures the decoded instruction bundle, then drives the ALU operands (A, B, 3-bit control) and the EX-stage control/store data. Forwards from EX/MEM and MEM/WB. Inserts one bubble and stalls IF/ID on a load-use hazard.

Parameters:
DATA_W, 32, datapath width
REG_AW, 5, register-file address width

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  asynchronous, active-high reset
flush  in  1  branch/jump redirect; kill incoming instruction
hold_in  in  1  downstream stall; freeze ID/EX contents
id_valid  in  1  decode bundle valid
id_rs, id_rt, id_rd  in  REG_AW  source/destination register numbers
id_uses_rt  in  1  instruction reads rt as a source
id_rdata1, id_rdata2  in  DATA_W  register-file read data
id_imm  in  DATA_W  sign-extended immediate
id_alu_ctrl  in  3  ALU op (000 AND, 001 OR, 010 ADD, 110 SUB, 111 SLT)
id_alu_src, id_reg_dst, id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg  in  1  decode control
exm_reg_write  in  1  EX/MEM writes a register
exm_rd  in  REG_AW  EX/MEM destination
exm_result  in  DATA_W  EX/MEM ALU result
mwb_reg_write  in  1  MEM/WB writes a register
mwb_rd  in  REG_AW  MEM/WB destination
mwb_data  in  DATA_W  MEM/WB writeback data
stall_out  out  1  freeze PC and IF/ID this cycle
ex_valid  out  1  ID/EX holds a real instruction
alu_a, alu_b  out  DATA_W  ALU operands
alu_ctrl  out  3  ALU op
ex_store_data  out  DATA_W  forwarded rt value for stores
ex_wreg  out  REG_AW  destination: rd if reg_dst else rt
ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg  out  1  registered control

Behaviour:
- Reset (async, any time): all registered fields 0, so ex_valid=0, all control outputs 0, alu_ctrl=000. alu_a/alu_b/ex_store_data then resolve combinationally from zeroed registers (0 unless forwarding matches reg 0, which is never forwarded).
- Load-use hazard (combinational): haz = ex_valid & ex_mem_read & ex_wreg!=0 & id_valid & (ex_wreg==id_rs | (id_uses_rt & ex_wreg==id_rt)).
- stall_out = (haz | hold_in) & !flush.
- Update priority at each clock edge:
  - flush=1: load bubble (ex_valid=0, all control 0), regardless of hold_in.
  - hold_in=1: keep all contents.
  - haz=1: load bubble. Decode bundle is retained upstream and re-presented the next cycle.
  - Otherwise: load the decode bundle. Control bits are gated by id_valid, so id_valid=0 loads a bubble.
- Latency: one cycle from decode bundle to ALU operands. Exactly one bubble per load-use hazard.
- Forwarding (combinational on registered rs/rt):
  - Source X = EX/MEM if exm_reg_write & exm_rd!=0 & exm_rd==reg.
  - Else MEM/WB if mwb_reg_write & mwb_rd!=0 & mwb_rd==reg.
  - Else the registered read data.
  - EX/MEM has priority when both match.
- alu_a = fwd(rs). ex_store_data = fwd(rt). alu_b = ex_alu_src ? imm : fwd(rt).
- ex_wreg is computed at capture: reg_dst ? rd : rt.
- Bubble state never asserts reg_write, mem_read or mem_write, so no false hazard and no false forward originates from it.

Test Plan:
- Reset mid-operation: load ADD, assert rst asynchronously between edges -> ex_valid, ex_reg_write, alu_ctrl drop to 0 immediately, without waiting for a clock edge.
- Plain capture: rdata1=5, rdata2=7, ctrl=010, alu_src=0, reg_dst=1, rd=3, no forwarding match -> next cycle alu_a=5, alu_b=7, ex_wreg=3, ex_valid=1.
- Forward priority: ID/EX rs=4; exm_rd=4, exm_result=0x11; mwb_rd=4, mwb_data=0x22 -> alu_a=0x11. Drop exm_reg_write -> alu_a=0x22. rs=0 with exm_rd=0 -> alu_a=registered data.
- Load-use: ID/EX holds LW with wreg=8. Decode presents SUB rs=8 -> stall_out=1 for one cycle, then bubble (ex_valid=0). Next cycle SUB captured, and alu_a is forwarded from MEM/WB once the load reaches writeback.
- Load-use rt not used: same as above but id_uses_rt=0 and rt=8 -> no stall.
- Flush vs hold: hold_in=1 freezes contents for 3 cycles and stall_out=1. flush=1 together with hold_in=1 -> bubble loaded and stall_out=0.

Source files
------------

// File: rtl/id_ex_operand_stage.sv
// ID/EX pipeline register with operand forwarding and load-use hazard detection.
// Ports:
//   clk, rst           : clock and asynchronous active-high reset
//   flush, hold_in     : redirect (kill incoming) and downstream freeze
//   id_*               : decoded instruction bundle from the ID stage
//   exm_*, mwb_*       : writeback candidates from EX/MEM and MEM/WB
//   stall_out          : freeze PC and IF/ID this cycle
//   ex_valid, ex_*     : registered EX-stage control and destination
//   alu_a, alu_b       : forwarded ALU operands; alu_ctrl is the ALU op
//   ex_store_data      : forwarded rt value for stores
module id_ex_operand_stage #(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned REG_AW = 5
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush,
   input  logic              hold_in,
   input  logic              id_valid,
   input  logic [REG_AW-1:0] id_rs,
   input  logic [REG_AW-1:0] id_rt,
   input  logic [REG_AW-1:0] id_rd,
   input  logic              id_uses_rt,
   input  logic [DATA_W-1:0] id_rdata1,
   input  logic [DATA_W-1:0] id_rdata2,
   input  logic [DATA_W-1:0] id_imm,
   input  logic [2:0]        id_alu_ctrl,
   input  logic              id_alu_src,
   input  logic              id_reg_dst,
   input  logic              id_reg_write,
   input  logic              id_mem_read,
   input  logic              id_mem_write,
   input  logic              id_mem_to_reg,
   input  logic              exm_reg_write,
   input  logic [REG_AW-1:0] exm_rd,
   input  logic [DATA_W-1:0] exm_result,
   input  logic              mwb_reg_write,
   input  logic [REG_AW-1:0] mwb_rd,
   input  logic [DATA_W-1:0] mwb_data,
   output logic              stall_out,
   output logic              ex_valid,
   output logic [DATA_W-1:0] alu_a,
   output logic [DATA_W-1:0] alu_b,
   output logic [2:0]        alu_ctrl,
   output logic [DATA_W-1:0] ex_store_data,
   output logic [REG_AW-1:0] ex_wreg,
   output logic              ex_reg_write,
   output logic              ex_mem_read,
   output logic              ex_mem_write,
   output logic              ex_mem_to_reg
);

   logic [REG_AW-1:0] rs_q;
   logic [REG_AW-1:0] rt_q;
   logic [DATA_W-1:0] rdata1_q;
   logic [DATA_W-1:0] rdata2_q;
   logic [DATA_W-1:0] imm_q;
   logic              alu_src_q;

   logic              haz;
   logic              load_en;
   logic              kill;
   logic [DATA_W-1:0] fwd_rs;
   logic [DATA_W-1:0] fwd_rt;

   // Load-use: instruction in EX is a load whose result the decoding instruction needs.
   always_comb begin
      haz = ex_valid & ex_mem_read & (ex_wreg != '0) & id_valid &
            ((ex_wreg == id_rs) | (id_uses_rt & (ex_wreg == id_rt)));
   end

   assign stall_out = (haz | hold_in) & ~flush;

   // Flush overrides hold; otherwise hold freezes, and a hazard or invalid bundle inserts a bubble.
   assign load_en = flush | ~hold_in;
   assign kill    = flush | haz | ~id_valid;

   // Pipeline register; bubbles clear every field so nothing stale can hazard or forward.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ex_valid      <= 1'b0;
         rs_q          <= '0;
         rt_q          <= '0;
         rdata1_q      <= '0;
         rdata2_q      <= '0;
         imm_q         <= '0;
         alu_ctrl      <= 3'b000;
         alu_src_q     <= 1'b0;
         ex_wreg       <= '0;
         ex_reg_write  <= 1'b0;
         ex_mem_read   <= 1'b0;
         ex_mem_write  <= 1'b0;
         ex_mem_to_reg <= 1'b0;
      end else if (load_en) begin
         if (kill) begin
            ex_valid      <= 1'b0;
            rs_q          <= '0;
            rt_q          <= '0;
            rdata1_q      <= '0;
            rdata2_q      <= '0;
            imm_q         <= '0;
            alu_ctrl      <= 3'b000;
            alu_src_q     <= 1'b0;
            ex_wreg       <= '0;
            ex_reg_write  <= 1'b0;
            ex_mem_read   <= 1'b0;
            ex_mem_write  <= 1'b0;
            ex_mem_to_reg <= 1'b0;
         end else begin
            ex_valid      <= 1'b1;
            rs_q          <= id_rs;
            rt_q          <= id_rt;
            rdata1_q      <= id_rdata1;
            rdata2_q      <= id_rdata2;
            imm_q         <= id_imm;
            alu_ctrl      <= id_alu_ctrl;
            alu_src_q     <= id_alu_src;
            ex_wreg       <= id_reg_dst ? id_rd : id_rt;
            ex_reg_write  <= id_reg_write;
            ex_mem_read   <= id_mem_read;
            ex_mem_write  <= id_mem_write;
            ex_mem_to_reg <= id_mem_to_reg;
         end
      end
   end

   // Forwarding muxes: youngest producer (EX/MEM) wins; register 0 is never forwarded.
   always_comb begin
      fwd_rs = rdata1_q;
      if (exm_reg_write && (exm_rd != '0) && (exm_rd == rs_q)) begin
         fwd_rs = exm_result;
      end else if (mwb_reg_write && (mwb_rd != '0) && (mwb_rd == rs_q)) begin
         fwd_rs = mwb_data;
      end

      fwd_rt = rdata2_q;
      if (exm_reg_write && (exm_rd != '0) && (exm_rd == rt_q)) begin
         fwd_rt = exm_result;
      end else if (mwb_reg_write && (mwb_rd != '0) && (mwb_rd == rt_q)) begin
         fwd_rt = mwb_data;
      end
   end

   assign alu_a         = fwd_rs;
   assign alu_b         = alu_src_q ? imm_q : fwd_rt;
   assign ex_store_data = fwd_rt;

endmodule

// File: tb/tb_id_ex_operand_stage.sv
// Self-checking bench for id_ex_operand_stage: directed scenarios plus a
// randomized run compared against a behavioural model of the ID/EX stage.
module tb_id_ex_operand_stage;

   logic        clk = 1'b0;
   logic        rst;
   logic        flush, hold_in, id_valid, id_uses_rt;
   logic [4:0]  id_rs, id_rt, id_rd;
   logic [31:0] id_rdata1, id_rdata2, id_imm;
   logic [2:0]  id_alu_ctrl;
   logic        id_alu_src, id_reg_dst, id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg;
   logic        exm_reg_write, mwb_reg_write;
   logic [4:0]  exm_rd, mwb_rd;
   logic [31:0] exm_result, mwb_data;
   logic        stall_out, ex_valid;
   logic [31:0] alu_a, alu_b, ex_store_data;
   logic [2:0]  alu_ctrl;
   logic [4:0]  ex_wreg;
   logic        ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   id_ex_operand_stage dut (
      .clk(clk), .rst(rst), .flush(flush), .hold_in(hold_in), .id_valid(id_valid),
      .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .id_uses_rt(id_uses_rt),
      .id_rdata1(id_rdata1), .id_rdata2(id_rdata2), .id_imm(id_imm),
      .id_alu_ctrl(id_alu_ctrl), .id_alu_src(id_alu_src), .id_reg_dst(id_reg_dst),
      .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
      .id_mem_to_reg(id_mem_to_reg),
      .exm_reg_write(exm_reg_write), .exm_rd(exm_rd), .exm_result(exm_result),
      .mwb_reg_write(mwb_reg_write), .mwb_rd(mwb_rd), .mwb_data(mwb_data),
      .stall_out(stall_out), .ex_valid(ex_valid), .alu_a(alu_a), .alu_b(alu_b),
      .alu_ctrl(alu_ctrl), .ex_store_data(ex_store_data), .ex_wreg(ex_wreg),
      .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
      .ex_mem_to_reg(ex_mem_to_reg)
   );

   // Instruction currently held in the EX stage, as the model sees it.
   typedef struct {
      bit       valid;
      bit [4:0] rs, rt, dest;
      bit [31:0] a_val, b_val, imm;
      bit [2:0] op;
      bit       use_imm, wr, ld, st, m2r;
   } ex_instr_t;

   ex_instr_t m_ex;

   task automatic idle();
      flush = 0; hold_in = 0; id_valid = 0; id_uses_rt = 0;
      id_rs = 0; id_rt = 0; id_rd = 0; id_rdata1 = 0; id_rdata2 = 0; id_imm = 0;
      id_alu_ctrl = 0; id_alu_src = 0; id_reg_dst = 0; id_reg_write = 0;
      id_mem_read = 0; id_mem_write = 0; id_mem_to_reg = 0;
      exm_reg_write = 0; exm_rd = 0; exm_result = 0;
      mwb_reg_write = 0; mwb_rd = 0; mwb_data = 0;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Value of register r as seen by EX: newest in-flight writer first.
   function automatic bit [31:0] m_operand(input bit [4:0] r, input bit [31:0] file_val);
      if (r == 0) return file_val;
      if (exm_reg_write && exm_rd == r) return exm_result;
      if (mwb_reg_write && mwb_rd == r) return mwb_data;
      return file_val;
   endfunction

   function automatic bit m_hazard();
      bit needs;
      needs = (id_rs == m_ex.dest) || (id_uses_rt && id_rt == m_ex.dest);
      return m_ex.valid && m_ex.ld && m_ex.dest != 0 && id_valid && needs;
   endfunction

   task automatic test_reset();
      idle();
      rst = 1;
      #2;
      checks++;
      if ({ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, alu_ctrl} !== 8'h0 ||
          alu_a !== 0 || alu_b !== 0 || ex_store_data !== 0 || ex_wreg !== 0) begin
         failures++;
         $display("FAIL reset_state: valid=%b ctrl=%b a=%h b=%h wreg=%0d required all zero",
                  ex_valid, alu_ctrl, alu_a, alu_b, ex_wreg);
      end
      @(negedge clk);
      rst = 0;
      // Load an ADD, then assert reset between edges.
      tick();
      id_valid = 1; id_alu_ctrl = 3'b010; id_reg_write = 1; id_reg_dst = 1; id_rd = 6;
      tick();
      idle();
      #2;
      checks++;
      if (ex_valid !== 1'b1 || ex_reg_write !== 1'b1 || alu_ctrl !== 3'b010) begin
         failures++;
         $display("FAIL reset_preload: valid=%b rw=%b ctrl=%b required 1 1 010",
                  ex_valid, ex_reg_write, alu_ctrl);
      end
      rst = 1;
      #1;
      checks++;
      if (ex_valid !== 1'b0 || ex_reg_write !== 1'b0 || alu_ctrl !== 3'b000) begin
         failures++;
         $display("FAIL reset_async: valid=%b rw=%b ctrl=%b required 0 0 000",
                  ex_valid, ex_reg_write, alu_ctrl);
      end
      @(negedge clk);
      rst = 0;
   endtask

   task automatic test_capture();
      idle();
      id_valid = 1; id_rs = 1; id_rt = 2; id_rd = 3; id_rdata1 = 5; id_rdata2 = 7;
      id_imm = 32'h0000_0040; id_alu_ctrl = 3'b010; id_reg_dst = 1; id_reg_write = 1;
      tick();
      idle();
      @(negedge clk);
      checks++;
      if (alu_a !== 5 || alu_b !== 7 || ex_wreg !== 3 || ex_valid !== 1'b1 || alu_ctrl !== 3'b010) begin
         failures++;
         $display("FAIL capture_rr: a=%0d b=%0d wreg=%0d valid=%b ctrl=%b required 5 7 3 1 010",
                  alu_a, alu_b, ex_wreg, ex_valid, alu_ctrl);
      end
      // Immediate form with rt as destination.
      tick();
      id_valid = 1; id_rs = 1; id_rt = 9; id_rd = 3; id_rdata1 = 5; id_rdata2 = 7;
      id_imm = 32'hFFFF_FFF0; id_alu_ctrl = 3'b001; id_alu_src = 1; id_reg_write = 1;
      tick();
      idle();
      @(negedge clk);
      checks++;
      if (alu_b !== 32'hFFFF_FFF0 || ex_store_data !== 7 || ex_wreg !== 9) begin
         failures++;
         $display("FAIL capture_imm: b=%h store=%h wreg=%0d required fffffff0 7 9",
                  alu_b, ex_store_data, ex_wreg);
      end
   endtask

   task automatic test_forward();
      tick();
      idle();
      id_valid = 1; id_rs = 4; id_rt = 6; id_rdata1 = 32'h99; id_rdata2 = 32'h66; id_reg_write = 1;
      tick();
      idle();
      exm_reg_write = 1; exm_rd = 4; exm_result = 32'h11;
      mwb_reg_write = 1; mwb_rd = 4; mwb_data = 32'h22;
      @(negedge clk);
      checks++;
      if (alu_a !== 32'h11) begin
         failures++;
         $display("FAIL fwd_exm_priority: a=%h required 11", alu_a);
      end
      exm_reg_write = 0;
      #1;
      checks++;
      if (alu_a !== 32'h22) begin
         failures++;
         $display("FAIL fwd_mwb: a=%h required 22", alu_a);
      end
      mwb_rd = 6;
      #1;
      checks++;
      if (alu_a !== 32'h99 || ex_store_data !== 32'h22 || alu_b !== 32'h22) begin
         failures++;
         $display("FAIL fwd_rt: a=%h store=%h b=%h required 99 22 22", alu_a, ex_store_data, alu_b);
      end
      // Register 0 is never forwarded.
      tick();
      idle();
      id_valid = 1; id_rs = 0; id_rdata1 = 32'h33; id_reg_write = 1;
      tick();
      idle();
      exm_reg_write = 1; exm_rd = 0; exm_result = 32'hDEAD;
      mwb_reg_write = 1; mwb_rd = 0; mwb_data = 32'hBEEF;
      @(negedge clk);
      checks++;
      if (alu_a !== 32'h33) begin
         failures++;
         $display("FAIL fwd_reg0: a=%h required 33", alu_a);
      end
   endtask

   task automatic test_load_use();
      tick();
      idle();
      // LW into r8.
      id_valid = 1; id_rs = 2; id_rt = 8; id_imm = 4; id_alu_ctrl = 3'b010; id_alu_src = 1;
      id_reg_write = 1; id_mem_read = 1; id_mem_to_reg = 1; id_uses_rt = 0;
      tick();
      idle();
      // SUB r10 = r8 - r9.
      id_valid = 1; id_rs = 8; id_rt = 9; id_rd = 10; id_uses_rt = 1; id_reg_dst = 1;
      id_rdata1 = 32'h5555; id_rdata2 = 3; id_alu_ctrl = 3'b110; id_reg_write = 1;
      @(negedge clk);
      checks++;
      if (stall_out !== 1'b1 || ex_wreg !== 8) begin
         failures++;
         $display("FAIL loaduse_stall: stall=%b wreg=%0d required 1 8", stall_out, ex_wreg);
      end
      tick();
      exm_reg_write = 1; exm_rd = 8; exm_result = 32'h100;
      @(negedge clk);
      checks++;
      if (stall_out !== 1'b0 || ex_valid !== 1'b0 || ex_reg_write !== 1'b0) begin
         failures++;
         $display("FAIL loaduse_bubble: stall=%b valid=%b rw=%b required 0 0 0",
                  stall_out, ex_valid, ex_reg_write);
      end
      tick();
      idle();
      mwb_reg_write = 1; mwb_rd = 8; mwb_data = 32'hABCD;
      @(negedge clk);
      checks++;
      if (ex_valid !== 1'b1 || alu_a !== 32'hABCD || alu_b !== 3 || alu_ctrl !== 3'b110 || ex_wreg !== 10) begin
         failures++;
         $display("FAIL loaduse_capture: valid=%b a=%h b=%h ctrl=%b wreg=%0d required 1 abcd 3 110 10",
                  ex_valid, alu_a, alu_b, alu_ctrl, ex_wreg);
      end
   endtask

   task automatic test_rt_unused();
      tick();
      idle();
      id_valid = 1; id_rs = 2; id_rt = 8; id_alu_src = 1; id_reg_write = 1; id_mem_read = 1;
      tick();
      idle();
      id_valid = 1; id_rs = 1; id_rt = 8; id_uses_rt = 0; id_alu_src = 1; id_rdata1 = 32'h77;
      id_reg_write = 1;
      @(negedge clk);
      checks++;
      if (stall_out !== 1'b0) begin
         failures++;
         $display("FAIL rt_unused_nostall: stall=%b required 0", stall_out);
      end
      id_uses_rt = 1;
      #1;
      checks++;
      if (stall_out !== 1'b1) begin
         failures++;
         $display("FAIL rt_used_stall: stall=%b required 1", stall_out);
      end
      id_uses_rt = 0;
      tick();
      idle();
      @(negedge clk);
      checks++;
      if (ex_valid !== 1'b1 || alu_a !== 32'h77 || ex_mem_read !== 1'b0) begin
         failures++;
         $display("FAIL rt_unused_capture: valid=%b a=%h mr=%b required 1 77 0",
                  ex_valid, alu_a, ex_mem_read);
      end
   endtask

   task automatic test_flush_hold();
      tick();
      idle();
      id_valid = 1; id_rs = 1; id_rd = 5; id_reg_dst = 1; id_rdata1 = 32'h44; id_reg_write = 1;
      id_alu_ctrl = 3'b010;
      tick();
      idle();
      hold_in = 1; id_valid = 1; id_rs = 2; id_rd = 7; id_reg_dst = 1; id_rdata1 = 32'h77;
      id_reg_write = 1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         checks++;
         if (stall_out !== 1'b1 || ex_valid !== 1'b1 || alu_a !== 32'h44 || ex_wreg !== 5) begin
            failures++;
            $display("FAIL hold_cycle%0d: stall=%b valid=%b a=%h wreg=%0d required 1 1 44 5",
                     i, stall_out, ex_valid, alu_a, ex_wreg);
         end
         tick();
      end
      flush = 1;
      @(negedge clk);
      checks++;
      if (stall_out !== 1'b0) begin
         failures++;
         $display("FAIL flush_stall: stall=%b required 0", stall_out);
      end
      tick();
      idle();
      @(negedge clk);
      checks++;
      if (ex_valid !== 1'b0 || ex_reg_write !== 1'b0) begin
         failures++;
         $display("FAIL flush_bubble: valid=%b rw=%b required 0 0", ex_valid, ex_reg_write);
      end
   endtask

   task automatic test_random();
      bit        exp_stall;
      bit [31:0] exp_b;
      ex_instr_t nxt;
      tick();
      idle();
      rst = 1;
      #1;
      rst = 0;
      m_ex = '{default: 0};
      for (int cyc = 0; cyc < 3000; cyc++) begin
         flush         = ($urandom_range(0, 99) < 8);
         hold_in       = ($urandom_range(0, 99) < 15);
         id_valid      = ($urandom_range(0, 99) < 80);
         id_rs         = 5'($urandom_range(0, 3));
         id_rt         = 5'($urandom_range(0, 3));
         id_rd         = 5'($urandom_range(0, 3));
         id_uses_rt    = 1'($urandom);
         id_rdata1     = $urandom;
         id_rdata2     = $urandom;
         id_imm        = $urandom;
         id_alu_ctrl   = 3'($urandom);
         id_alu_src    = 1'($urandom);
         id_reg_dst    = 1'($urandom);
         id_reg_write  = 1'($urandom);
         id_mem_read   = ($urandom_range(0, 99) < 35);
         id_mem_write  = 1'($urandom);
         id_mem_to_reg = 1'($urandom);
         exm_reg_write = 1'($urandom);
         exm_rd        = 5'($urandom_range(0, 3));
         exm_result    = $urandom;
         mwb_reg_write = 1'($urandom);
         mwb_rd        = 5'($urandom_range(0, 3));
         mwb_data      = $urandom;
         @(negedge clk);
         exp_stall = (m_hazard() || hold_in) && !flush;
         checks++;
         if (stall_out !== exp_stall) begin
            failures++;
            $display("FAIL rand_stall cyc=%0d: got %b required %b", cyc, stall_out, exp_stall);
         end
         checks++;
         if ({ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg} !==
             {m_ex.valid, m_ex.wr, m_ex.ld, m_ex.st, m_ex.m2r}) begin
            failures++;
            $display("FAIL rand_ctrl cyc=%0d: got %b%b%b%b%b required %b%b%b%b%b", cyc,
                     ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg,
                     m_ex.valid, m_ex.wr, m_ex.ld, m_ex.st, m_ex.m2r);
         end
         if (m_ex.valid) begin
            exp_b = m_ex.use_imm ? m_ex.imm : m_operand(m_ex.rt, m_ex.b_val);
            checks++;
            if (alu_a !== m_operand(m_ex.rs, m_ex.a_val) || alu_b !== exp_b ||
                ex_store_data !== m_operand(m_ex.rt, m_ex.b_val)) begin
               failures++;
               $display("FAIL rand_operands cyc=%0d: a=%h b=%h sd=%h required %h %h %h", cyc,
                        alu_a, alu_b, ex_store_data, m_operand(m_ex.rs, m_ex.a_val), exp_b,
                        m_operand(m_ex.rt, m_ex.b_val));
            end
            checks++;
            if (ex_wreg !== m_ex.dest || alu_ctrl !== m_ex.op) begin
               failures++;
               $display("FAIL rand_dest cyc=%0d: wreg=%0d op=%b required %0d %b", cyc,
                        ex_wreg, alu_ctrl, m_ex.dest, m_ex.op);
            end
         end
         // Advance the model: flush kills, hold freezes, hazard or invalid inserts a bubble.
         nxt = m_ex;
         if (flush || (!hold_in && (m_hazard() || !id_valid))) begin
            nxt = '{default: 0};
         end else if (!hold_in) begin
            nxt.valid   = 1;
            nxt.rs      = id_rs;
            nxt.rt      = id_rt;
            nxt.dest    = id_reg_dst ? id_rd : id_rt;
            nxt.a_val   = id_rdata1;
            nxt.b_val   = id_rdata2;
            nxt.imm     = id_imm;
            nxt.op      = id_alu_ctrl;
            nxt.use_imm = id_alu_src;
            nxt.wr      = id_reg_write;
            nxt.ld      = id_mem_read;
            nxt.st      = id_mem_write;
            nxt.m2r     = id_mem_to_reg;
         end
         tick();
         m_ex = nxt;
      end
   endtask

   initial begin
      idle();
      rst = 1;
      test_reset();
      test_capture();
      test_forward();
      test_load_use();
      test_rt_unused();
      test_flush_hold();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
